// File: rtl/pa_risc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pa_risc_pkg : access-size encodings and responder FSM states       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pa_risc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for a reserved size or an access not aligned to its own size.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a_lo[0];
            SZ_WORD: bad = |a_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder_array : four byte-lane storage with big-endian steer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_responder_array
    import pa_risc_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [7:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    localparam int ROWS  = DEPTH / 4;
    localparam int ROW_W = $clog2(ROWS);

    logic [ROW_W-1:0] w_row;
    logic [1:0]       w_lane;
    logic [1:0]       w_lane_nx;
    logic [3:0]       w_lane_we;
    logic [3:0][7:0]  w_lane_wd;
    logic [3:0][7:0]  w_lane_rd;

    assign w_row     = i_addr[ROW_W+1:2];
    assign w_lane    = i_addr[1:0];
    assign w_lane_nx = w_lane | 2'b01;

    // Lane 0 holds the lowest address of a row, so it receives the MSB of a word.
    always_comb begin
        w_lane_we = '0;
        w_lane_wd = '0;
        case (i_size)
            SZ_BYTE: begin
                w_lane_we[w_lane] = 1'b1;
                w_lane_wd[w_lane] = i_wdata[7:0];
            end
            SZ_HALF: begin
                w_lane_we[w_lane]    = 1'b1;
                w_lane_wd[w_lane]    = i_wdata[15:8];
                w_lane_we[w_lane_nx] = 1'b1;
                w_lane_wd[w_lane_nx] = i_wdata[7:0];
            end
            SZ_WORD: begin
                w_lane_we = 4'b1111;
                for (int l = 0; l < 4; l++) begin
                    w_lane_wd[l] = i_wdata[31-8*l -: 8];
                end
            end
            default: begin
                w_lane_we = '0;
            end
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_mem [ROWS];

        always_ff @(posedge i_clk) begin
            if (i_we && w_lane_we[l]) begin
                r_mem[w_row] <= w_lane_wd[l];
            end
        end

        assign w_lane_rd[l] = r_mem[w_row];
    end

    always_comb begin
        o_rdata = '0;
        case (i_size)
            SZ_BYTE: o_rdata = {24'b0, w_lane_rd[w_lane]};
            SZ_HALF: o_rdata = {16'b0, w_lane_rd[w_lane], w_lane_rd[w_lane_nx]};
            SZ_WORD: o_rdata = {w_lane_rd[0], w_lane_rd[1], w_lane_rd[2], w_lane_rd[3]};
            default: o_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder : valid/ready memory responder with fixed latency    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_responder
    import pa_risc_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  A,
    input  logic [31:0] DI,
    input  logic [1:0]  Size,
    input  logic        RW,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] DO,
    output logic        err
);

    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_rw;
    logic [31:0] r_do;
    logic        r_err;

    logic        w_accept;
    logic        w_fire;
    logic        w_bad;
    logic        w_we;
    logic [31:0] w_rdata;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    // The last WAIT cycle: the edge ending it enters RESP and touches storage.
    assign w_fire   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_bad    = access_bad(r_size, r_addr[1:0]);
    assign w_we     = w_fire && r_rw && !w_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= 8'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'd0;
            r_rw    <= 1'b0;
            r_do    <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= A;
                r_wdata <= DI;
                r_size  <= Size;
                r_rw    <= RW;
                r_cnt   <= c_LAT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_fire) begin
                r_err <= w_bad;
                r_do  <= (w_bad || r_rw) ? 32'd0 : w_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign DO  = r_do;
    assign err = r_err;

    mem_responder_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_size  (r_size),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_responder : self-checking bench for mem_responder           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_responder;

    localparam int LAT0 = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, RW, rsp_valid, rsp_ready, err;
    logic [7:0]  A;
    logic [31:0] DI, DO;
    logic [1:0]  Size;

    logic        v1, rdy1, rw1, rv1, rr1, err1;
    logic [7:0]  a1;
    logic [31:0] di1, do1;
    logic [1:0]  sz1;

    int          checks;
    int          errors;
    logic [7:0]  ref_mem [256];

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [7:0]  a;
        logic [31:0] di;
        logic [31:0] exp_do;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];

    mem_responder #(.LATENCY(LAT0), .DEPTH(256)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .A(A), .DI(DI), .Size(Size), .RW(RW), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .DO(DO), .err(err)
    );

    mem_responder #(.LATENCY(1), .DEPTH(256)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .A(a1), .DI(di1), .Size(sz1), .RW(rw1), .rsp_valid(rv1),
        .rsp_ready(rr1), .DO(do1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, big-endian, size-aligned accesses only.
    task automatic mdl(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                       input logic [31:0] di, output logic [31:0] d, output logic e);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        if (n == 0) e = 1'b1;
        else        e = ((int'(a) % n) != 0);
        d = 32'd0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (rw) ref_mem[int'(a) + i] = 8'(di >> (8 * (n - 1 - i)));
                else    d = (d << 8) | 32'(ref_mem[int'(a) + i]);
            end
        end
    endtask

    task automatic xfer(input string nm, input logic rw, input logic [1:0] sz,
                        input logic [7:0] a, input logic [31:0] di, input int hold,
                        input logic [31:0] exp_do, input logic exp_err);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; RW = rw; Size = sz; A = a; DI = di; rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Inputs change freely while the request is in flight.
        req_valid = 1'($urandom_range(0, 1));
        RW = 1'($urandom); Size = 2'($urandom); A = 8'($urandom); DI = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(LAT0));
        chk({nm, "_do"}, DO, exp_do);
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, "_hold_do"}, DO, exp_do);
            chk({nm, "_hold_err"}, 32'(err), 32'(exp_err));
            chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk({nm, "_ready_after"}, 32'(req_ready), 32'd1);
        chk({nm, "_valid_after"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_do_kept"}, DO, exp_do);
    endtask

    logic        t_rw;
    logic [1:0]  t_sz;
    logic [7:0]  t_a;
    logic [31:0] t_di, t_do;
    logic        t_e;
    int          seen;

    logic        rq_rw [4];
    logic [1:0]  rq_sz [4];
    logic [7:0]  rq_a  [4];
    logic [31:0] rq_di [4];
    logic [31:0] rq_do [4];
    int          acc_cyc [4];
    int          nacc, nrsp, cyc;
    logic        will_acc;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        A = '0; DI = '0; Size = '0; RW = 1'b0;
        v1 = 1'b0; rr1 = 1'b0; a1 = '0; di1 = '0; sz1 = '0; rw1 = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_do", DO, 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        reset = 1'b1;

        // Give every byte a known value.
        for (int w = 0; w < 64; w++) begin
            t_di = $urandom;
            mdl(1'b1, 2'b10, 8'(w * 4), t_di, t_do, t_e);
            xfer("fill", 1'b1, 2'b10, 8'(w * 4), t_di, 0, t_do, t_e);
        end

        tbl[0]  = '{1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'b10, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 8'h11, 32'h0,        32'h000000AD, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 8'h12, 32'h0,        32'h0000BEEF, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 8'h12, 32'h11111111, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 2'b10, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 8'h13, 32'h0000AAAA, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 2'b11, 8'h10, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b0, 2'b10, 8'h11, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, 2'b00, 8'h13, 32'hFFFFFF77, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 2'b10, 8'h10, 32'h0,        32'hDEADBE77, 1'b0};
        tbl[11] = '{1'b1, 2'b01, 8'h10, 32'hABCD1234, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 2'b10, 8'h10, 32'h0,        32'h1234BE77, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 8'h10, 32'h0,        32'h00000012, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 8'hFC, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 2'b01, 8'hFE, 32'h0,        32'h0000F00D, 1'b0};
        tbl[16] = '{1'b0, 2'b10, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[17] = '{1'b0, 2'b01, 8'h11, 32'h0,        32'h0,        1'b1};
        for (int i = 0; i < 18; i++) begin
            mdl(tbl[i].rw, tbl[i].sz, tbl[i].a, tbl[i].di, t_do, t_e);
            xfer($sformatf("vec%0d", i), tbl[i].rw, tbl[i].sz, tbl[i].a, tbl[i].di, 0,
                 tbl[i].exp_do, tbl[i].exp_err);
        end

        // Backpressure: response held five cycles.
        mdl(1'b0, 2'b10, 8'h10, 32'h0, t_do, t_e);
        xfer("backpressure", 1'b0, 2'b10, 8'h10, 32'h0, 5, t_do, t_e);
        mdl(1'b1, 2'b10, 8'h12, 32'h0, t_do, t_e);
        xfer("bp_err", 1'b1, 2'b10, 8'h12, 32'h0, 3, t_do, t_e);

        // Reset while a byte write is in flight.
        mdl(1'b1, 2'b00, 8'h20, 32'hA3, t_do, t_e);
        xfer("pre_reset", 1'b1, 2'b00, 8'h20, 32'hA3, 0, t_do, t_e);
        req_valid = 1'b1; RW = 1'b1; Size = 2'b00; A = 8'h20; DI = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("midreset_no_rsp", 32'(seen), 32'd0);
        mdl(1'b0, 2'b00, 8'h20, 32'h0, t_do, t_e);
        xfer("post_reset_read", 1'b0, 2'b00, 8'h20, 32'h0, 0, t_do, t_e);

        // Random traffic against the reference model.
        for (int k = 0; k < 200; k++) begin
            t_rw = 1'($urandom_range(0, 1));
            t_sz = 2'($urandom_range(0, 3));
            t_a  = 8'($urandom);
            t_di = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (t_sz == 2'b01) t_a[0] = 1'b0;
                if (t_sz == 2'b10) t_a[1:0] = 2'b00;
            end
            mdl(t_rw, t_sz, t_a, t_di, t_do, t_e);
            xfer("rand", t_rw, t_sz, t_a, t_di, int'($urandom_range(0, 2)), t_do, t_e);
        end

        // LATENCY=1 instance, back-to-back with rsp_ready tied high.
        rq_rw[0] = 1'b1; rq_sz[0] = 2'b10; rq_a[0] = 8'h40; rq_di[0] = 32'hA5A50F0F; rq_do[0] = 32'h0;
        rq_rw[1] = 1'b1; rq_sz[1] = 2'b10; rq_a[1] = 8'h44; rq_di[1] = 32'h01234567; rq_do[1] = 32'h0;
        rq_rw[2] = 1'b0; rq_sz[2] = 2'b10; rq_a[2] = 8'h40; rq_di[2] = 32'h0;        rq_do[2] = 32'hA5A50F0F;
        rq_rw[3] = 1'b0; rq_sz[3] = 2'b01; rq_a[3] = 8'h46; rq_di[3] = 32'h0;        rq_do[3] = 32'h00004567;
        for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
        @(posedge clk); #1;
        rr1 = 1'b1; v1 = 1'b1;
        rw1 = rq_rw[0]; sz1 = rq_sz[0]; a1 = rq_a[0]; di1 = rq_di[0];
        will_acc = rdy1;
        cyc = 0; nacc = 0; nrsp = 0;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (will_acc) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 4) begin
                    rw1 = rq_rw[nacc]; sz1 = rq_sz[nacc]; a1 = rq_a[nacc]; di1 = rq_di[nacc];
                end else begin
                    v1 = 1'b0;
                end
            end
            if (rv1 && nrsp < nacc) begin
                chk("lat1_latency", 32'(cyc - acc_cyc[nrsp]), 32'd1);
                chk("lat1_do", do1, rq_do[nrsp]);
                chk("lat1_err", 32'(err1), 32'd0);
                nrsp++;
            end
            will_acc = v1 && rdy1;
        end
        chk("lat1_responses", 32'(nrsp), 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk("lat1_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        v1 = 1'b0; rr1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-002 SHALL have parameter DEPTH, default 256, meaning the storage size in bytes, addressed by A[7:0].
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request this cycle.
REQ-007 SHALL have port A  input  8  byte address.
REQ-008 SHALL have port DI  input  32  write data, right-justified.
REQ-009 SHALL have port Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SHALL have port RW  input  1  access direction: 1 write, 0 read.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  the initiator accepts the response.
REQ-013 SHALL have port DO  output  32  read data, zero-extended and right-justified.
REQ-014 SHALL have port err  output  1  the response reports a misaligned or reserved-size request.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on an edge where req_valid=1 and req_ready=1, capture A, DI, Size and RW into internal registers, and move to WAIT.
REQ-017 SHALL load a 4-bit counter with LATENCY-1 on acceptance, decrement it each WAIT cycle, and move to RESP on the edge where the counter is 0.
REQ-018 SHALL therefore assert rsp_valid exactly LATENCY cycles after the accepting edge; with LATENCY=1, rsp_valid rises on the first edge after acceptance.
REQ-019 SHALL perform the storage access on the edge that enters RESP: a write commits its bytes, and a read registers DO.
REQ-020 SHALL store data big-endian: a word places DI[31:24] at A and DI[7:0] at A+3; a halfword places DI[15:8] at A and DI[7:0] at A+1; a byte places DI[7:0] at A.
REQ-021 SHALL zero-extend read data, giving DO={24'b0,byte} for a byte read and DO={16'b0,half} for a halfword read.
REQ-022 SHALL set err=1 and suppress both the write and the read for any of these conditions: halfword with A[0]=1; word with A[1:0]≠00; Size=11.
REQ-023 SHALL drive DO=0 for every write response and every err response.
REQ-024 SHALL hold rsp_valid, DO and err stable in RESP until rsp_ready=1.
REQ-025 SHALL return to IDLE on the edge where rsp_valid=1 and rsp_ready=1; a new request is acceptable on the following edge, so the minimum period is LATENCY+2 cycles per transfer.
REQ-026 SHALL hold DO and err at their last response values outside RESP, and SHALL drive rsp_valid=0 outside RESP.
REQ-027 SHALL ignore input changes while in WAIT or RESP, using only the captured copies.
REQ-028 SHALL service requests strictly in order; a read following a write to the same address SHALL return the written data.
REQ-029 SHALL keep an address wrap-around at 0xFF within a single access impossible, because aligned accesses cannot cross the top of storage.

Reset
REQ-030 SHALL, while reset=0, force state=IDLE, req_ready=1, rsp_valid=0, DO=0, err=0, counter=0 and all captured request registers to 0.
REQ-031 SHALL abort any in-flight request when reset is asserted mid-operation; a write not yet committed SHALL never commit, and no response SHALL be issued for it.
REQ-032 SHALL leave storage contents unchanged by reset; storage is uninitialised at power-up.
REQ-033 SHALL resume operation on the first rising clk edge after reset deasserts.

Structure
REQ-034 SHALL take the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding from the shared package pa_risc_pkg.
REQ-035 SHALL place the byte-lane storage array and the big-endian lane steering in one sub-module, mem_responder_array; the FSM, counter and handshake logic SHALL stay in mem_responder.

Verification
REQ-036 Bench SHALL cover LATENCY=2: write word 0xDEADBEEF at A=0x10, then read word at 0x10 -> rsp_valid exactly 2 cycles after each accept, and the read returns DO=0xDEADBEEF with err=0.
REQ-037 Bench SHALL cover lane steering: after REQ-036, read byte at 0x11 -> DO=0x000000AD; read halfword at 0x12 -> DO=0x0000BEEF.
REQ-038 Bench SHALL cover misalignment: write word 0x11111111 at A=0x12 -> err=1 and DO=0, and a subsequent word read at 0x10 still returns 0xDEADBEEF.
REQ-039 Bench SHALL cover backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, DO and err remain stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
REQ-040 Bench SHALL cover reset mid-operation: assert reset one cycle after accepting write byte 0x55 at 0x20 -> rsp_valid never rises, and a later byte read at 0x20 returns the prior contents.
REQ-041 Bench SHALL cover LATENCY=1 back-to-back transfers with rsp_ready=1: two reads -> each rsp_valid comes 1 cycle after its accept, and accepts occur every 3 cycles.
